// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_sel_e       : next-PC source selected by the priority mux
//   DEF_*          : default parameter values for a 32-bit PC
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET,
        SEL_EXC
    } pc_sel_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_RAS_DEPTH = 4;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam logic [DEF_ADDR_W-1:0] DEF_PC_STEP = DEF_ADDR_W'(4);
    localparam logic [DEF_ADDR_W-1:0] DEF_PC_LIMIT = DEF_ADDR_W'(84);
    localparam logic [DEF_ADDR_W-1:0] DEF_EXC_VECTOR = DEF_ADDR_W'('h40);

endpackage

// File: rtl/pc_ras.sv
// Return-address stack with circular overwrite of the oldest entry when full.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (empties the stack)
//   clear      empty the stack (exception)
//   push       push push_data; when full the oldest entry is lost
//   pop        pop the top entry; ignored (underflow pulse) when empty
//   push_data  address to push
//   top        current top-of-stack entry (meaningless when empty)
//   empty      count == 0
//   full       count == RAS_DEPTH
//   overflow   registered one-cycle pulse: push happened while full
//   underflow  registered one-cycle pulse: pop happened while empty
module pc_ras #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0]   sp_q;   // next free slot; wraps so a full push hits the oldest entry
    logic [CntW-1:0]   cnt_q;
    logic              ovf_q;
    logic              unf_q;
    logic              do_push;
    logic [PtrW-1:0]   top_idx;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CntW'(RAS_DEPTH));
    assign top_idx   = sp_q - 1'b1;
    assign top       = mem_q[top_idx];
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign do_push   = push && !pop && !clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (clear) begin
                sp_q  <= '0;
                cnt_q <= '0;
            end else if (pop) begin
                if (empty) begin
                    unf_q <= 1'b1;
                end else begin
                    sp_q  <= sp_q - 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (push) begin
                sp_q <= sp_q + 1'b1;
                if (full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer.
// Ports:
//   Clock         rising-edge clock
//   Reset         synchronous active-low reset
//   WriteEnable   1 = advance PC, 0 = stall (exceptions still apply)
//   BranchTaken   redirect to BranchTarget
//   BranchTarget  branch destination
//   Jump          redirect to JumpTarget
//   Call          with Jump: push PC+PC_STEP onto the return-address stack
//   Return        redirect to popped return address
//   JumpTarget    jump/call destination
//   Exception     redirect to EXC_VECTOR and clear the return-address stack
//   PC            current (registered) PC
//   PCValid       PC is fetchable (low during reset and the hold cycle after it)
//   RasEmpty      return-address stack empty
//   RasFull       return-address stack full
//   RasOverflow   one-cycle pulse: call while stack full
//   RasUnderflow  one-cycle pulse: return while stack empty
//   LimitWrap     one-cycle pulse: selected next PC exceeded PC_LIMIT
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP    = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] PC_LIMIT   = DEF_PC_LIMIT,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic              Call,
    input  logic              Return,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Exception,
    output logic [ADDR_W-1:0] PC,
    output logic              PCValid,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              RasOverflow,
    output logic              RasUnderflow,
    output logic              LimitWrap
);

    logic [ADDR_W-1:0] pc_q;
    logic              hold_q;
    logic              wrap_q;
    pc_sel_e           sel;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ret_pc;
    logic [ADDR_W-1:0] sel_pc;
    logic              over_limit;
    logic              advance;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_clear;
    logic [ADDR_W-1:0] ras_top;

    // Carry out of the increment is dropped; the wrapped value still goes through the limit check.
    assign seq_pc     = pc_q + PC_STEP;
    assign ret_pc     = RasEmpty ? RESET_PC : ras_top;
    assign over_limit = (sel_pc > PC_LIMIT);

    assign advance   = !hold_q && WriteEnable && !Exception;
    assign ras_push  = advance && (sel == SEL_JMP) && Call;
    assign ras_pop   = advance && (sel == SEL_RET);
    assign ras_clear = !hold_q && Exception;

    always_comb begin
        sel = SEL_SEQ;
        if (Exception) begin
            sel = SEL_EXC;
        end else if (Return) begin
            sel = SEL_RET;
        end else if (Jump) begin
            sel = SEL_JMP;
        end else if (BranchTaken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        sel_pc = seq_pc;
        unique case (sel)
            SEL_EXC: sel_pc = EXC_VECTOR;
            SEL_RET: sel_pc = ret_pc;
            SEL_JMP: sel_pc = JumpTarget;
            SEL_BR:  sel_pc = BranchTarget;
            SEL_SEQ: sel_pc = seq_pc;
            default: sel_pc = seq_pc;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q   <= RESET_PC;
            hold_q <= 1'b1;
            wrap_q <= 1'b0;
        end else if (hold_q) begin
            hold_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (Exception) begin
            pc_q   <= EXC_VECTOR;
            wrap_q <= 1'b0;
        end else if (WriteEnable) begin
            pc_q   <= over_limit ? RESET_PC : sel_pc;
            wrap_q <= over_limit;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clock),
        .rst_n     (Reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (RasEmpty),
        .full      (RasFull),
        .overflow  (RasOverflow),
        .underflow (RasUnderflow)
    );

    assign PC        = pc_q;
    assign PCValid   = !hold_q;
    assign LimitWrap = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;
    localparam logic [31:0] LIMIT = 32'd84;
    localparam logic [31:0] EXCV  = 32'h40;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        WriteEnable = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic        Call = 1'b0;
    logic        Return = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        Exception = 1'b0;
    logic [31:0] PC;
    logic        PCValid;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasOverflow;
    logic        RasUnderflow;
    logic        LimitWrap;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .Clock        (clk),
        .Reset        (Reset),
        .WriteEnable  (WriteEnable),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .Call         (Call),
        .Return       (Return),
        .JumpTarget   (JumpTarget),
        .Exception    (Exception),
        .PC           (PC),
        .PCValid      (PCValid),
        .RasEmpty     (RasEmpty),
        .RasFull      (RasFull),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow),
        .LimitWrap    (LimitWrap)
    );

    // Reference model: the return-address stack is a plain queue, newest at the back.
    logic [31:0] m_pc = '0;
    logic        m_hold = 1'b1;
    logic        m_ov = 1'b0;
    logic        m_un = 1'b0;
    logic        m_lw = 1'b0;
    logic [31:0] ras_q[$];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic we, input logic br,
                              input logic [31:0] bt, input logic j, input logic c,
                              input logic rt, input logic [31:0] jt, input logic e);
        logic [31:0] nxt;
        m_ov = 1'b0;
        m_un = 1'b0;
        m_lw = 1'b0;
        if (!r) begin
            m_pc   = '0;
            m_hold = 1'b1;
            ras_q.delete();
        end else if (m_hold) begin
            m_hold = 1'b0;
        end else if (e) begin
            m_pc = EXCV;
            ras_q.delete();
        end else if (we) begin
            if (rt) begin
                if (ras_q.size() == 0) begin
                    nxt  = '0;
                    m_un = 1'b1;
                end else begin
                    nxt = ras_q.pop_back();
                end
            end else if (j) begin
                if (c) begin
                    if (ras_q.size() == DEPTH) begin
                        void'(ras_q.pop_front());
                        m_ov = 1'b1;
                    end
                    ras_q.push_back(m_pc + STEP);
                end
                nxt = jt;
            end else if (br) begin
                nxt = bt;
            end else begin
                nxt = m_pc + STEP;
            end
            m_lw = (nxt > LIMIT);
            m_pc = m_lw ? 32'd0 : nxt;
        end
    endtask

    task automatic check_all();
        check("pc", PC, m_pc);
        check("pc_valid", 32'(PCValid), 32'(!m_hold));
        check("ras_empty", 32'(RasEmpty), 32'(ras_q.size() == 0));
        check("ras_full", 32'(RasFull), 32'(ras_q.size() == DEPTH));
        check("ras_overflow", 32'(RasOverflow), 32'(m_ov));
        check("ras_underflow", 32'(RasUnderflow), 32'(m_un));
        check("limit_wrap", 32'(LimitWrap), 32'(m_lw));
    endtask

    task automatic step(input logic r, input logic we, input logic br, input logic [31:0] bt,
                        input logic j, input logic c, input logic rt, input logic [31:0] jt,
                        input logic e);
        Reset        = r;
        WriteEnable  = we;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = j;
        Call         = c;
        Return       = rt;
        JumpTarget   = jt;
        Exception    = e;
        @(posedge clk);
        model_edge(r, we, br, bt, j, c, rt, jt, e);
        #1;
        check_all();
    endtask

    task automatic seq();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic call(input logic [31:0] t);
        step(1, 1, 0, 0, 1, 1, 0, t, 0);
    endtask

    task automatic ret();
        step(1, 1, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        // 1: reset, hold cycle, then sequential fetch
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", PC, 32'd0);
        check("reset_valid", 32'(PCValid), 32'd0);
        step(1, 1, 1, 32'h20, 0, 0, 0, 0, 0);  // request ignored in hold cycle
        check("hold_pc", PC, 32'd0);
        check("hold_valid", 32'(PCValid), 32'd1);
        seq();
        seq();
        check("seq_pc8", PC, 32'd8);

        // 2: limit wrap on sequential and on branch
        for (int i = 0; i < 40 && m_pc != LIMIT; i++) seq();
        check("reach_limit", PC, LIMIT);
        seq();
        check("seq_wrap_pc", PC, 32'd0);
        check("seq_wrap_pulse", 32'(LimitWrap), 32'd1);
        step(1, 1, 1, 32'h60, 0, 0, 0, 0, 0);
        check("br_wrap_pc", PC, 32'd0);
        check("br_wrap_pulse", 32'(LimitWrap), 32'd1);

        // 3: call then return
        seq();
        seq();
        call(32'h30);
        check("call_pc", PC, 32'h30);
        check("call_nonempty", 32'(RasEmpty), 32'd0);
        ret();
        check("ret_pc", PC, 32'h0C);
        check("ret_empty", 32'(RasEmpty), 32'd1);

        // 4: overflow and underflow
        for (int i = 1; i <= 5; i++) call(32'(i * 16));
        check("ovf_pulse", 32'(RasOverflow), 32'd1);
        check("ovf_full", 32'(RasFull), 32'd1);
        for (int i = 0; i < 5; i++) ret();
        check("unf_pc", PC, 32'd0);
        check("unf_pulse", 32'(RasUnderflow), 32'd1);

        // 5: stall holds, exception during stall still applies
        call(32'h20);
        step(1, 0, 1, 32'h10, 0, 0, 0, 0, 0);
        check("stall_pc", PC, 32'h20);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("stall_exc_pc", PC, EXCV);
        check("stall_exc_empty", 32'(RasEmpty), 32'd1);

        // 6: exception priority, reset over exception
        call(32'h30);
        step(1, 1, 1, 32'h10, 0, 0, 1, 0, 1);
        check("exc_prio_pc", PC, EXCV);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("rst_exc_pc", PC, 32'd0);
        check("rst_exc_valid", 32'(PCValid), 32'd0);
        seq();
        check("rst_exc_hold", PC, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) == 0,
                 32'($urandom_range(0, 30)) * 4,
                 $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0,
                 32'($urandom_range(0, 30)) * 4,
                 $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
